// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and sizing helpers for the serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a 1-bit counter vector.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_chunk_cell.sv
// rtl/serial_subtractor_sub_chunk_cell.sv - combinational CHUNK-bit ripple-borrow subtractor
module sub_chunk_cell #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             bin,
    output logic [CHUNK-1:0] d_c,
    output logic             bout
);

    always_comb begin
        logic bw;
        bw  = bin;
        d_c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            d_c[i] = a_c[i] ^ b_c[i] ^ bw;
            bw     = (~a_c[i] & b_c[i]) | (~(a_c[i] ^ b_c[i]) & bw);
        end
        bout = bw;
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle a - b - borrow_in, CHUNK bits per clock, valid/ready on both sides
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;

    logic [CHUNK-1:0]       d_c;
    logic                   bout;
    logic [WIDTH+CHUNK-1:0] diff_shift;
    logic                   last_chunk;

    sub_chunk_cell #(
        .CHUNK(CHUNK)
    ) u_cell (
        .a_c  (a_q[CHUNK-1:0]),
        .b_c  (b_q[CHUNK-1:0]),
        .bin  (brw_q),
        .d_c  (d_c),
        .bout (bout)
    );

    // New chunks enter at the MSB end so the result lines up after NCHUNK shifts.
    assign diff_shift = {d_c, diff_q};
    assign last_chunk = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            brw_q        <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            brw_q        <= brw_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        brw_d        = brw_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
            brw_d   = borrow_in;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d    = a_q >> CHUNK;
            b_d    = b_q >> CHUNK;
            brw_d  = bout;
            diff_d = diff_shift[WIDTH+CHUNK-1:CHUNK];
            cnt_d  = cnt_q + CW'(1);
            if (last_chunk) begin
                cnt_d        = '0;
                borrow_out_d = bout;
                // Sign bits were captured at accept; the operand registers have shifted away.
                overflow_d   = (a_msb_q != b_msb_q) && (d_c[CHUNK-1] != a_msb_q);
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench over three serial_subtractor configurations
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  in_valid, in_ready, out_valid, out_ready, borrow_in, borrow_out, overflow;
    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    logic [7:0]  diff0, diff2;
    logic [15:0] diff1;
    logic [15:0] diff_w [3];

    always_comb begin
        diff_w[0] = {8'h00, diff0};
        diff_w[1] = diff1;
        diff_w[2] = {8'h00, diff2};
    end

    serial_subtractor #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .borrow_in(borrow_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .diff(diff0),
        .borrow_out(borrow_out[0]), .overflow(overflow[0])
    );

    serial_subtractor #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_s[1]), .b(b_s[1]), .borrow_in(borrow_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .diff(diff1),
        .borrow_out(borrow_out[1]), .overflow(overflow[1])
    );

    serial_subtractor #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_s[2][7:0]), .b(b_s[2][7:0]), .borrow_in(borrow_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .diff(diff2),
        .borrow_out(borrow_out[2]), .overflow(overflow[2])
    );

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int width_of(input int i);
        return (i == 1) ? 16 : 8;
    endfunction

    function automatic int nchunk_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 4 : 1;
    endfunction

    function automatic exp_t model(input int i, input logic [15:0] a, input logic [15:0] b, input logic bin);
        exp_t   e;
        int     w;
        longint mask, av, bv, r;
        logic   sa, sb_bit;
        w      = width_of(i);
        mask   = (longint'(1) << w) - 1;
        av     = longint'(a) & mask;
        bv     = longint'(b) & mask;
        r      = av - bv - longint'(bin);
        e.diff = 16'(r & mask);
        e.bout = (av < bv + longint'(bin));
        sa     = a[w-1];
        sb_bit = b[w-1];
        e.ovf  = (sa != sb_bit) && (e.diff[w-1] != sa);
        return e;
    endfunction

    task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input int hold, input bit poke);
        exp_t e;
        int   lat;
        out_ready[i] = (hold == 0);
        a_s[i]       = a;
        b_s[i]       = b;
        borrow_in[i] = bin;
        in_valid[i]  = 1'b1;
        check_eq("in_ready_idle", 32'(in_ready[i]), 32'd1);
        sb.push_back(model(i, a, b, bin));
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        lat = 0;
        check_eq("in_ready_run", 32'(in_ready[i]), 32'd0);
        if (poke) begin
            a_s[i]       = 16'($urandom);
            b_s[i]       = 16'($urandom);
            borrow_in[i] = ~bin;
            in_valid[i]  = 1'b1;
            @(posedge clk); #1;
            in_valid[i] = 1'b0;
            lat = 1;
        end
        while (!out_valid[i] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat + 1), 32'(nchunk_of(i) + 1));
        e = sb.pop_front();
        if (out_valid[i]) begin
            check_eq("diff", 32'(diff_w[i]), 32'(e.diff));
            check_eq("borrow_out", 32'(borrow_out[i]), 32'(e.bout));
            check_eq("overflow", 32'(overflow[i]), 32'(e.ovf));
        end
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                a_s[i]      = 16'($urandom);
                in_valid[i] = 1'b1;
            end
            @(posedge clk); #1;
            check_eq("hold_out_valid", 32'(out_valid[i]), 32'd1);
            check_eq("hold_in_ready", 32'(in_ready[i]), 32'd0);
            check_eq("hold_diff", 32'(diff_w[i]), 32'(e.diff));
            check_eq("hold_borrow", 32'(borrow_out[i]), 32'(e.bout));
            check_eq("hold_overflow", 32'(overflow[i]), 32'(e.ovf));
        end
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        check_eq("out_valid_drop", 32'(out_valid[i]), 32'd0);
        check_eq("in_ready_back", 32'(in_ready[i]), 32'd1);
        check_eq("diff_held_idle", 32'(diff_w[i]), 32'(e.diff));
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_eq({tag, "_in_ready"}, 32'(in_ready[i]), 32'd1);
            check_eq({tag, "_out_valid"}, 32'(out_valid[i]), 32'd0);
            check_eq({tag, "_diff"}, 32'(diff_w[i]), 32'd0);
            check_eq({tag, "_borrow_out"}, 32'(borrow_out[i]), 32'd0);
            check_eq({tag, "_overflow"}, 32'(overflow[i]), 32'd0);
        end
    endtask

    initial begin
        in_valid  = '0;
        out_ready = '1;
        borrow_in = '0;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = '0;
            b_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 16'h05, 16'h03, 1'b0, 0, 1'b0);
        do_op(0, 16'h03, 16'h05, 1'b0, 0, 1'b0);
        do_op(0, 16'h80, 16'h01, 1'b0, 0, 1'b0);
        do_op(0, 16'h00, 16'h00, 1'b1, 0, 1'b0);
        do_op(0, 16'h77, 16'h77, 1'b0, 0, 1'b0);
        do_op(0, 16'hC3, 16'h5A, 1'b1, 5, 1'b1);

        // Abort an operation in its third RUN cycle.
        a_s[0]       = 16'h5A;
        b_s[0]       = 16'h33;
        borrow_in[0] = 1'b0;
        in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 16'h05, 16'h03, 1'b0, 0, 1'b0);

        do_op(1, 16'h1234, 16'h0FFF, 1'b0, 0, 1'b0);
        do_op(1, 16'h0000, 16'h0000, 1'b1, 2, 1'b1);
        do_op(1, 16'h8000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(2, 16'h05, 16'h03, 1'b0, 0, 1'b0);
        do_op(2, 16'h00, 16'h00, 1'b1, 3, 1'b1);
        do_op(2, 16'h7F, 16'hFF, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++)
            do_op(1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        for (int n = 0; n < 100; n++)
            do_op(0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        for (int n = 0; n < 100; n++)
            do_op(2, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
